vga_rx_monitor: RTL

VGA_RX_MONITOR -- requirements
Module: vga_rx_monitor

---
 rtl/vga_timing_pkg.sv | 35 +++
 rtl/vga_axis_tracker.sv | 63 ++++++
 rtl/vga_rx_monitor.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/vga_timing_pkg.sv
`default_nettype none
// ============================================================================
// Module      : vga_timing_pkg
// Description : Default 640x480 timing constants, FSM encoding and helpers
//               shared by the VGA receive monitor.
// Revision    : 1.0 - initial release
// ============================================================================
package vga_timing_pkg;

    localparam int c_h_sync  = 96;
    localparam int c_h_bp    = 48;
    localparam int c_h_vis   = 640;
    localparam int c_h_total = 800;
    localparam int c_v_sync  = 2;
    localparam int c_v_bp    = 33;
    localparam int c_v_vis   = 480;
    localparam int c_v_total = 525;

    localparam int c_cnt_w   = 11;

    typedef enum logic [1:0] {
        ST_SEARCH  = 2'd0,
        ST_MEASURE = 2'd1,
        ST_LOCKED  = 2'd2
    } state_t;

    // Half-open interval test: lo <= val < hi
    function automatic logic in_span(input logic [c_cnt_w-1:0] val,
                                     input logic [c_cnt_w-1:0] lo,
                                     input logic [c_cnt_w-1:0] hi);
        return (val >= lo) && (val < hi);
    endfunction

endpackage
`default_nettype wire

// File: rtl/vga_axis_tracker.sv
`default_nettype none
// ============================================================================
// Module      : vga_axis_tracker
// Description : One timing axis: sync edge detect, position counter and
//               sync-low width measurement.
// Revision    : 1.0 - initial release
// ============================================================================
module vga_axis_tracker
    import vga_timing_pkg::*;
#(
    parameter int SYNC_WIDTH = 96
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_sample,
    input  logic               i_sync,
    input  logic               i_step,
    output logic               o_fall,
    output logic               o_width_err,
    output logic [c_cnt_w-1:0] o_cnt,
    output logic [c_cnt_w-1:0] o_cnt_next
);

    localparam logic [c_cnt_w-1:0] c_width = c_cnt_w'(SYNC_WIDTH);

    logic               r_sync_prev;
    logic [c_cnt_w-1:0] r_cnt;
    logic [c_cnt_w-1:0] r_width;
    logic               w_rise;

    assign o_fall      = i_sample &  r_sync_prev & ~i_sync;
    assign w_rise      = i_sample & ~r_sync_prev &  i_sync;
    assign o_width_err = w_rise & (r_width != c_width);
    assign o_cnt       = r_cnt;

    always_comb begin
        o_cnt_next = r_cnt;
        if (o_fall) begin
            o_cnt_next = '0;
        end else if (i_step) begin
            o_cnt_next = r_cnt + 1'b1;
        end
    end

    // Width counts the falling sample as 1, then every step with sync still low
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync_prev <= 1'b1;
            r_cnt       <= '0;
            r_width     <= '0;
        end else if (i_sample) begin
            r_sync_prev <= i_sync;
            r_cnt       <= o_cnt_next;
            if (o_fall) begin
                r_width <= c_cnt_w'(1);
            end else if (i_step && !i_sync && (r_width != '1)) begin
                r_width <= r_width + 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/vga_rx_monitor.sv
`default_nettype none
// ============================================================================
// Module      : vga_rx_monitor
// Description : Locks onto an incoming VGA stream, recovers row/column of
//               visible pixels, checksums each frame and counts timing errors.
// Revision    : 1.0 - initial release
// ============================================================================
module vga_rx_monitor
    import vga_timing_pkg::*;
#(
    parameter int H_SYNC  = c_h_sync,
    parameter int H_BP    = c_h_bp,
    parameter int H_VIS   = c_h_vis,
    parameter int H_TOTAL = c_h_total,
    parameter int V_SYNC  = c_v_sync,
    parameter int V_BP    = c_v_bp,
    parameter int V_VIS   = c_v_vis,
    parameter int V_TOTAL = c_v_total
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        pix_en,
    input  logic        hs,
    input  logic        vs,
    input  logic [2:0]  red,
    input  logic [2:0]  green,
    input  logic [1:0]  blue,
    output logic        locked,
    output logic        pixel_valid,
    output logic [10:0] row,
    output logic [10:0] column,
    output logic        frame_done,
    output logic [15:0] frame_sum,
    output logic [7:0]  err_count
);

    localparam logic [c_cnt_w-1:0] c_h_last  = c_cnt_w'(H_TOTAL - 1);
    localparam logic [c_cnt_w-1:0] c_v_last  = c_cnt_w'(V_TOTAL - 1);
    localparam logic [c_cnt_w-1:0] c_h_start = c_cnt_w'(H_SYNC + H_BP);
    localparam logic [c_cnt_w-1:0] c_h_end   = c_cnt_w'(H_SYNC + H_BP + H_VIS);
    localparam logic [c_cnt_w-1:0] c_v_start = c_cnt_w'(V_SYNC + V_BP);
    localparam logic [c_cnt_w-1:0] c_v_end   = c_cnt_w'(V_SYNC + V_BP + V_VIS);

    state_t             r_state, w_state_next;
    logic               r_meas_ok, w_meas_ok_next;
    logic               w_hs_fall, w_vs_fall, w_hs_width_err, w_vs_width_err;
    logic [c_cnt_w-1:0] r_hcnt, w_hcnt_next, r_vcnt, w_vcnt_next;
    logic               w_line_err, w_frame_err, w_timing_err;
    logic               w_is_locked, w_valid;
    logic [15:0]        r_sum, w_sum_next;
    logic               r_pixel_valid, r_frame_done;
    logic [c_cnt_w-1:0] r_row, r_column;
    logic [15:0]        r_frame_sum;
    logic [7:0]         r_err_count;

    vga_axis_tracker #(.SYNC_WIDTH(H_SYNC)) u_h_axis (
        .clk         (clk),
        .rst         (reset),
        .i_sample    (pix_en),
        .i_sync      (hs),
        .i_step      (pix_en),
        .o_fall      (w_hs_fall),
        .o_width_err (w_hs_width_err),
        .o_cnt       (r_hcnt),
        .o_cnt_next  (w_hcnt_next)
    );

    // Vertical axis advances one line per horizontal sync falling edge
    vga_axis_tracker #(.SYNC_WIDTH(V_SYNC)) u_v_axis (
        .clk         (clk),
        .rst         (reset),
        .i_sample    (pix_en),
        .i_sync      (vs),
        .i_step      (w_hs_fall),
        .o_fall      (w_vs_fall),
        .o_width_err (w_vs_width_err),
        .o_cnt       (r_vcnt),
        .o_cnt_next  (w_vcnt_next)
    );

    assign w_line_err   = w_hs_fall & (r_hcnt != c_h_last);
    assign w_frame_err  = w_vs_fall & (r_vcnt != c_v_last);
    assign w_timing_err = w_line_err | w_frame_err | w_hs_width_err | w_vs_width_err;
    assign w_is_locked  = (r_state == ST_LOCKED);
    assign w_valid      = w_is_locked
                        & in_span(w_hcnt_next, c_h_start, c_h_end)
                        & in_span(w_vcnt_next, c_v_start, c_v_end);
    assign w_sum_next   = r_sum + (w_valid ? {8'd0, red, green, blue} : 16'd0);

    always_comb begin
        w_state_next   = r_state;
        w_meas_ok_next = r_meas_ok;
        case (r_state)
            ST_SEARCH: begin
                if (w_vs_fall) begin
                    w_state_next   = ST_MEASURE;
                    w_meas_ok_next = 1'b1;
                end
            end
            ST_MEASURE: begin
                // The line closing the frame is judged on the same sample
                if (w_vs_fall) begin
                    if (r_meas_ok && !w_line_err && !w_frame_err) begin
                        w_state_next = ST_LOCKED;
                    end
                    w_meas_ok_next = 1'b1;
                end else if (w_line_err) begin
                    w_meas_ok_next = 1'b0;
                end
            end
            ST_LOCKED: begin
                if (w_timing_err) begin
                    w_state_next = ST_SEARCH;
                end
            end
            default: w_state_next = ST_SEARCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= ST_SEARCH;
            r_meas_ok <= 1'b0;
        end else if (pix_en) begin
            r_state   <= w_state_next;
            r_meas_ok <= w_meas_ok_next;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sum         <= '0;
            r_frame_sum   <= '0;
            r_frame_done  <= 1'b0;
            r_pixel_valid <= 1'b0;
            r_row         <= '0;
            r_column      <= '0;
            r_err_count   <= '0;
        end else begin
            r_frame_done <= 1'b0;
            if (pix_en) begin
                r_pixel_valid <= w_valid;
                if (w_valid) begin
                    r_row    <= w_vcnt_next - c_v_start;
                    r_column <= w_hcnt_next - c_h_start;
                end
                if (w_is_locked && w_timing_err && (r_err_count != 8'hFF)) begin
                    r_err_count <= r_err_count + 8'd1;
                end
                if (w_vs_fall) begin
                    r_sum <= '0;
                    if (w_is_locked) begin
                        r_frame_sum  <= w_sum_next;
                        r_frame_done <= 1'b1;
                    end
                end else begin
                    r_sum <= w_sum_next;
                end
            end
        end
    end

    assign locked      = w_is_locked;
    assign pixel_valid = r_pixel_valid;
    assign row         = r_row;
    assign column      = r_column;
    assign frame_done  = r_frame_done;
    assign frame_sum   = r_frame_sum;
    assign err_count   = r_err_count;

endmodule
`default_nettype wire
